// File: rtl/stickman_actor.sv
// stickman_actor: stickman jump physics, run-animation paging and sprite pixel hit test.
// Define STICKMAN_DOUBLE_JUMP_EN to allow a single mid-air re-jump per airborne period.
module stickman_actor #(
  parameter int         X_POS     = 100,
  parameter int         FLOOR_Y   = 350,
  parameter int         CEIL_Y    = 10,
  parameter int         WIDTH     = 84,
  parameter int         HEIGHT    = 120,
  parameter int         N_FRAMES  = 9,
  parameter int         FRAME_DIV = 2,
  parameter int         JUMP_V    = 12,
  parameter int         GRAVITY   = 1,
  parameter int         MAX_FALL  = 12,
  parameter int         VEL_W     = 6,
  parameter logic [7:0] KEY_JUMP  = 8'h2c,
  parameter int         ADDR_W    = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [7:0]        keycode,
  input  logic              pause,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [WIDTH-1:0]  sprite_row,
  output logic [ADDR_W-1:0] sprite_addr,
  output logic              is_actor,
  output logic [9:0]        y_top,
  output logic              airborne,
  output logic [1:0]        jump_state
);

  localparam int GROUND_TOP = FLOOR_Y - HEIGHT;
  localparam int PAGE_W     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int SUB_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic signed [10:0] CEIL_S   = 11'(CEIL_Y);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_TOP);
  localparam logic signed [10:0] X_S      = 11'(X_POS);
  localparam logic signed [10:0] W_S      = 11'(WIDTH);
  localparam logic signed [10:0] H_S      = 11'(HEIGHT);
  localparam logic [9:0]         CEIL_Y10 = 10'(CEIL_Y);
  localparam logic [9:0]         GROUND_Y = 10'(GROUND_TOP);
  localparam logic [VEL_W-1:0]   JUMP_VEL = VEL_W'(JUMP_V);
  localparam logic [VEL_W-1:0]   GRAV_V   = VEL_W'(GRAVITY);
  localparam logic [VEL_W-1:0]   FALL_CAP = VEL_W'(MAX_FALL);
  localparam logic [ADDR_W-1:0]  H_A      = ADDR_W'(HEIGHT);

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } jump_t;

  jump_t              state;
  logic [VEL_W-1:0]   vel;
  logic [9:0]         y_reg;
  logic [PAGE_W-1:0]  page;
  logic [SUB_W-1:0]   sub;
  logic               fc_sync, fc_dly, tick;
  logic               key_now, dj_fire;
  logic               sub_wrap, page_last;
  logic signed [10:0] y_s, v_s, nt_rise, nt_fall;
  logic [VEL_W:0]     vel_inc;
  logic [VEL_W-1:0]   vel_capped;

  assign key_now   = (keycode == KEY_JUMP);
  assign sub_wrap  = (sub == SUB_W'(FRAME_DIV - 1));
  assign page_last = (page == PAGE_W'(N_FRAMES - 1));

  assign y_s     = signed'({1'b0, y_reg});
  assign v_s     = signed'(11'(vel));
  assign nt_rise = y_s - v_s;
  assign nt_fall = y_s + v_s;

  assign vel_inc    = {1'b0, vel} + (VEL_W+1)'(GRAVITY);
  assign vel_capped = (vel_inc > {1'b0, FALL_CAP}) ? FALL_CAP : vel_inc[VEL_W-1:0];

  // frame_clk is unrelated to Clk: one sync flop, then a one-cycle rising-edge pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_sync <= 1'b0;
      fc_dly  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      fc_sync <= frame_clk;
      fc_dly  <= fc_sync;
      tick    <= fc_sync & ~fc_dly;
    end
  end

`ifdef STICKMAN_DOUBLE_JUMP_EN
  logic key_prev, dj_used, press;

  assign press   = key_now & ~key_prev;
  assign dj_fire = (state != GROUND) & ~dj_used & press;

  // key_prev follows every tick, paused or not, so a key held through a pause is not a fresh press
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_prev <= 1'b0;
      dj_used  <= 1'b0;
    end else if (tick) begin
      key_prev <= key_now;
      if (!pause) begin
        if (dj_fire)
          dj_used <= 1'b1;
        else if (state == FALLING && nt_fall >= GROUND_S)
          dj_used <= 1'b0;
      end
    end
  end
`else
  assign dj_fire = 1'b0;
`endif

  // Motion and animation FSM; everything advances on an unpaused tick only
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= GROUND;
      y_reg    <= GROUND_Y;
      vel      <= '0;
      airborne <= 1'b0;
      page     <= '0;
      sub      <= '0;
    end else if (tick && !pause) begin
      if (dj_fire) begin
        vel      <= JUMP_VEL;
        state    <= RISING;
        airborne <= 1'b1;
      end else begin
        case (state)
          GROUND: begin
            if (key_now) begin
              vel      <= JUMP_VEL;
              state    <= RISING;
              airborne <= 1'b1;
            end else if (sub_wrap) begin
              sub  <= '0;
              page <= page_last ? '0 : page + PAGE_W'(1);
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
          RISING: begin
            if (nt_rise <= CEIL_S) begin
              y_reg <= CEIL_Y10;
              vel   <= '0;
              state <= FALLING;
            end else begin
              y_reg <= nt_rise[9:0];
              if (vel <= GRAV_V) begin
                vel   <= '0;
                state <= FALLING;
              end else begin
                vel <= vel - GRAV_V;
              end
            end
          end
          FALLING: begin
            // Landing tick snaps to the floor and leaves the animation untouched
            if (nt_fall >= GROUND_S) begin
              y_reg    <= GROUND_Y;
              vel      <= '0;
              state    <= GROUND;
              airborne <= 1'b0;
            end else begin
              y_reg <= nt_fall[9:0];
              vel   <= vel_capped;
            end
          end
          default: begin
            state    <= GROUND;
            airborne <= 1'b0;
          end
        endcase
      end
    end
  end

  assign y_top      = y_reg;
  assign jump_state = state;

  logic signed [10:0] dx, dy;
  logic [10:0]        dx_u;
  logic [WIDTH-1:0]   row_shift;
  logic               in_box;

  // Signed 11-bit offsets keep pixels above/left of the box negative instead of wrapping in
  assign dx        = signed'({1'b0, DrawX}) - X_S;
  assign dy        = signed'({1'b0, DrawY}) - y_s;
  assign dx_u      = dx;
  assign in_box    = (dx >= 0) && (dx < W_S) && (dy >= 0) && (dy < H_S);
  assign row_shift = sprite_row << dx_u;

  assign is_actor    = in_box & row_shift[WIDTH-1];
  assign sprite_addr = ADDR_W'(dy) + H_A * ADDR_W'(page);

endmodule

// File: tb/tb_stickman_actor.sv
// tb_stickman_actor: directed and randomized checks of two stickman_actor instances
// (default ceiling and a low ceiling of 180) against a frame-level behavioural model.
module tb_stickman_actor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic        pause;
  logic [9:0]  DrawX, DrawY;
  logic [83:0] sprite_row;

  logic [10:0] addrA, addrB;
  logic        hitA, hitB;
  logic [9:0]  yA, yB;
  logic        airA, airB;
  logic [1:0]  jsA, jsB;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model, one slot per instance
  int my[2], mv[2], ms[2], mpage[2], msub[2], mkp[2], mdj[2];
  int ceilY[2] = '{10, 180};

  int jumpY[26]  = '{230, 218, 207, 197, 188, 180, 173, 167, 162, 158, 155, 153, 152,
                     152, 153, 155, 158, 162, 167, 173, 180, 188, 197, 207, 218, 230};

  always #10 Clk = ~Clk;

  stickman_actor dutA (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .pause(pause),
    .DrawX(DrawX), .DrawY(DrawY), .sprite_row(sprite_row), .sprite_addr(addrA),
    .is_actor(hitA), .y_top(yA), .airborne(airA), .jump_state(jsA)
  );

  stickman_actor #(.CEIL_Y(180)) dutB (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .pause(pause),
    .DrawX(DrawX), .DrawY(DrawY), .sprite_row(sprite_row), .sprite_addr(addrB),
    .is_actor(hitB), .y_top(yB), .airborne(airB), .jump_state(jsB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      my[i] = 230; mv[i] = 0; ms[i] = 0; mpage[i] = 0; msub[i] = 0; mkp[i] = 0; mdj[i] = 0;
    end
  endtask

  // One frame tick: 0 ground, 1 rising, 2 falling
  task automatic modelTick(input bit keyNow, input bit paused);
    bit press;
    for (int i = 0; i < 2; i++) begin
      press  = keyNow && (mkp[i] == 0);
      mkp[i] = keyNow;
      if (paused) continue;
`ifdef STICKMAN_DOUBLE_JUMP_EN
      if (ms[i] != 0 && mdj[i] == 0 && press) begin
        mv[i] = 12; ms[i] = 1; mdj[i] = 1;
        continue;
      end
`endif
      if (ms[i] == 0) begin
        if (keyNow) begin
          mv[i] = 12; ms[i] = 1;
        end else begin
          msub[i]++;
          if (msub[i] == 2) begin
            msub[i] = 0;
            mpage[i] = (mpage[i] + 1) % 9;
          end
        end
      end else if (ms[i] == 1) begin
        if (my[i] - mv[i] <= ceilY[i]) begin
          my[i] = ceilY[i]; mv[i] = 0; ms[i] = 2;
        end else begin
          my[i] = my[i] - mv[i];
          if (mv[i] <= 1) begin mv[i] = 0; ms[i] = 2; end
          else mv[i] = mv[i] - 1;
        end
      end else begin
        if (my[i] + mv[i] >= 230) begin
          my[i] = 230; mv[i] = 0; ms[i] = 0; mdj[i] = 0;
        end else begin
          my[i] = my[i] + mv[i];
          mv[i] = (mv[i] + 1 > 12) ? 12 : mv[i] + 1;
        end
      end
    end
  endtask

  // Pulse frame_clk with the given keycode/pause held across the tick, then advance the model
  task automatic applyStimulus(input logic [7:0] key, input logic pz);
    keycode   = key;
    pause     = pz;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    keycode = $urandom_range(0, 1) ? 8'h2c : 8'h1d;
    pause   = $urandom_range(0, 1) ? 1'b1 : 1'b0;
    modelTick(key == 8'h2c, pz);
  endtask

  function automatic bit expHit(input int dx, input int dy);
    if (dx >= 0 && dx < 84 && dy >= 0 && dy < 120) return sprite_row[83 - dx];
    return 1'b0;
  endfunction

  task automatic checkAll(input string tag);
    int k, dxv, dyA, dyB;
    checkOutput({tag, "/yA"}, 32'(yA), 32'(my[0]));
    checkOutput({tag, "/jsA"}, 32'(jsA), 32'(ms[0]));
    checkOutput({tag, "/airA"}, 32'(airA), 32'(ms[0] != 0));
    checkOutput({tag, "/yB"}, 32'(yB), 32'(my[1]));
    checkOutput({tag, "/jsB"}, 32'(jsB), 32'(ms[1]));
    checkOutput({tag, "/airB"}, 32'(airB), 32'(ms[1] != 0));
    sprite_row = 84'({$urandom(), $urandom(), $urandom()});
    k = $urandom_range(0, 119);
    if ($urandom_range(0, 1) == 1) DrawY = 10'(my[0] + k);
    else DrawY = 10'($urandom_range(0, 479));
    DrawX = 10'($urandom_range(60, 220));
    #1;
    dxv = int'(DrawX) - 100;
    dyA = int'(DrawY) - my[0];
    dyB = int'(DrawY) - my[1];
    checkOutput({tag, "/addrA"}, 32'(addrA), 32'((dyA + 120 * mpage[0]) & 2047));
    checkOutput({tag, "/hitA"}, 32'(hitA), 32'(expHit(dxv, dyA)));
    checkOutput({tag, "/addrB"}, 32'(addrB), 32'((dyB + 120 * mpage[1]) & 2047));
    checkOutput({tag, "/hitB"}, 32'(hitB), 32'(expHit(dxv, dyB)));
  endtask

  task automatic doReset(input int cycles);
    Reset = 1'b1;
    frame_clk = 1'b0;
    repeat (cycles) @(negedge Clk);
    Reset = 1'b0;
    modelReset();
  endtask

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; keycode = 8'h00; pause = 1'b0;
    DrawX = '0; DrawY = '0; sprite_row = '1;
    @(negedge Clk);

    // Reset state
    doReset(3);
    #1;
    checkOutput("rst/y", 32'(yA), 32'd230);
    checkOutput("rst/js", 32'(jsA), 32'd0);
    checkOutput("rst/air", 32'(airA), 32'd0);
    checkOutput("rst/hit00", 32'(hitA), 32'd0);
    DrawY = 10'd230;
    #1;
    checkOutput("rst/addr", 32'(addrA), 32'd0);

    // Full jump on the default instance; low-ceiling instance clamps at 180
    applyStimulus(8'h2c, 1'b0);
    checkOutput("jump/y0", 32'(yA), 32'(jumpY[0]));
    checkOutput("jump/js0", 32'(jsA), 32'd1);
    checkAll("jump");
    for (int i = 1; i < 26; i++) begin
      applyStimulus(8'h00, 1'b0);
      checkOutput("jump/y", 32'(yA), 32'(jumpY[i]));
      checkOutput("jump/js", 32'(jsA), (i < 12) ? 32'd1 : (i < 25) ? 32'd2 : 32'd0);
      if (i == 5) begin
        checkOutput("ceil/yB", 32'(yB), 32'd180);
        checkOutput("ceil/jsB", 32'(jsB), 32'd2);
      end
      checkAll("jump");
    end

    // Grounded animation, page 3 address, pause freeze and page wrap
    doReset(2);
    for (int t = 1; t <= 18; t++) begin
      applyStimulus(8'h00, 1'b0);
      checkAll("anim");
      if (t == 6) begin
        DrawX = 10'd0; DrawY = 10'd235;
        #1;
        checkOutput("anim/addr365", 32'(addrA), 32'd365);
        for (int p = 0; p < 4; p++) applyStimulus(8'h2c, 1'b1);
        DrawY = 10'd235;
        #1;
        checkOutput("pause/addr365", 32'(addrA), 32'd365);
        checkOutput("pause/js", 32'(jsA), 32'd0);
        checkAll("pause");
      end
    end
    DrawY = 10'd230;
    #1;
    checkOutput("anim/wrap", 32'(addrA), 32'd0);

    // Pixel box edges
    sprite_row = {1'b1, 83'b0};
    DrawX = 10'd100; DrawY = 10'd230; #1;
    checkOutput("pix/hit100", 32'(hitA), 32'd1);
    DrawX = 10'd99; #1;
    checkOutput("pix/left99", 32'(hitA), 32'd0);
    sprite_row = '1;
    DrawX = 10'd184; #1;
    checkOutput("pix/right184", 32'(hitA), 32'd0);
    DrawX = 10'd183; #1;
    checkOutput("pix/right183", 32'(hitA), 32'd1);
    DrawY = 10'd229; #1;
    checkOutput("pix/above", 32'(hitA), 32'd0);
    DrawY = 10'd349; #1;
    checkOutput("pix/bottom349", 32'(hitA), 32'd1);
    DrawY = 10'd350; #1;
    checkOutput("pix/below350", 32'(hitA), 32'd0);

    // Reset in the middle of a jump
    applyStimulus(8'h2c, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0);
    checkAll("midjump");
    doReset(1);
    #1;
    checkOutput("midrst/y", 32'(yA), 32'd230);
    checkOutput("midrst/js", 32'(jsA), 32'd0);
    checkOutput("midrst/air", 32'(airA), 32'd0);
    checkAll("midrst");

    // Re-press at the apex, then a third press while still airborne
    doReset(2);
    applyStimulus(8'h2c, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h2c, 1'b0);
    checkOutput("dj/y", 32'(yA), 32'd152);
`ifdef STICKMAN_DOUBLE_JUMP_EN
    checkOutput("dj/js", 32'(jsA), 32'd1);
`else
    checkOutput("dj/js", 32'(jsA), 32'd2);
`endif
    checkAll("dj");
    applyStimulus(8'h00, 1'b0);
    checkAll("dj");
    applyStimulus(8'h2c, 1'b0);
    checkAll("dj3");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(8'h00, 1'b0);
      checkAll("djland");
    end

    // Randomized ticks
    doReset(2);
    for (int n = 0; n < 350; n++) begin
      logic [7:0] key;
      key = 8'($urandom_range(0, 255));
      if (key == 8'h2c) key = 8'h00;
      if ($urandom_range(0, 9) < 3) key = 8'h2c;
      applyStimulus(key, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
      checkAll("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
